// File: rtl/rosetta_loop_sequencer_pkg.sv
// Shared definitions for the ROSETTA loop sequencer: FSM states, instruction
// field positions and the packed control vector driven to memories/address gens.
package rosetta_loop_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_NOPS  = 2'd2,
    ST_FETCH = 2'd3
  } state_t;

  localparam int INST_MODE    = 0;
  localparam int INST_NOPS_EN = 1;
  localparam int INST_ENOF    = 16;

  // Field order is the bit order, MSB first (im_ren is bit 10, r_addr_rst bit 0).
  typedef struct packed {
    logic im_ren;
    logic pam_x_ren;
    logic pam_y_ren;
    logic pam_r_ren;
    logic pam_r_wen;
    logic wm_ren;
    logic bm_ren;
    logic x_addr_wen;
    logic r_addr_wen;
    logic x_addr_rst;
    logic r_addr_rst;
  } ctrl_t;

endpackage

// File: rtl/rosetta_loop_counter.sv
// Strided loop counter with an inclusive bound captured at load and a registered
// last flag that is valid in the same cycle as the count it describes.
module rosetta_loop_counter #(
  parameter int W    = 16,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] bound,
  output logic [W-1:0] count,
  output logic         last
);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] count_reg, count_next;
  logic [W-1:0] bound_reg, bound_next;
  logic         last_reg, last_next;

  // Remaining distance to the bound is compared, so a bound of all ones never overflows.
  always_comb begin
    count_next = count_reg;
    bound_next = bound_reg;
    last_next  = last_reg;
    if (load) begin
      bound_next = bound;
      count_next = '0;
      last_next  = bound < STEP_W;
    end else if (en) begin
      if (last_reg) begin
        count_next = '0;
        last_next  = bound_reg < STEP_W;
      end else begin
        count_next = count_reg + STEP_W;
        last_next  = (bound_reg - count_next) < STEP_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      bound_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      bound_reg <= bound_next;
      last_reg  <= last_next;
    end
  end

  assign count = count_reg;
  assign last  = last_reg;

endmodule

// File: rtl/rosetta_loop_sequencer.sv
// ROSETTA loop sequencer: accepts one instruction, walks the MAT inner/outer or
// ELEM element loop LANES elements per step, drains NOPs, then fetches the next.
module rosetta_loop_sequencer
  import rosetta_loop_sequencer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int NOPS_W = 8,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  input  logic [CNT_W-1:0]  beta_bound,
  input  logic [CNT_W-1:0]  p_bound,
  input  logic [NOPS_W-1:0] nops_count,
  input  logic              stall,
  output logic              im_ren,
  output logic              pam_x_ren,
  output logic              pam_y_ren,
  output logic              pam_r_ren,
  output logic              pam_r_wen,
  output logic              wm_ren,
  output logic              bm_ren,
  output logic              x_addr_wen,
  output logic              r_addr_wen,
  output logic              x_addr_rst,
  output logic              r_addr_rst,
  output logic [LANES-1:0]  lane_mask,
  output logic [CNT_W-1:0]  beta_idx,
  output logic [CNT_W-1:0]  p_idx,
  output logic              inst_done,
  output logic              busy
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t             state_reg, state_next;
  logic               mode_reg, enof_reg, nops_go_reg;
  logic [LANE_W-1:0]  tail_reg;
  logic               load, inner_en, outer_en, nops_step;
  logic [CNT_W-1:0]   inner_bound, outer_bound, inner_idx, outer_idx;
  logic               inner_last, outer_last, nops_last;
  logic [NOPS_W-1:0]  nops_idx_unused;
  logic [LANES-1:0]   lane_mask_run;
  logic               unused_inst;
  ctrl_t              ctrl;

  assign unused_inst = ^{inst[31:INST_ENOF+1], inst[INST_ENOF-1:INST_NOPS_EN+1]};

  // ELEM reuses the inner counter as its element loop with a single outer pass.
  assign inner_bound = inst[INST_MODE] ? p_bound : beta_bound;
  assign outer_bound = inst[INST_MODE] ? '0 : p_bound;

  rosetta_loop_counter #(.W(CNT_W), .STEP(LANES)) u_inner (
    .clk(clk), .rst(rst), .load(load), .en(inner_en),
    .bound(inner_bound), .count(inner_idx), .last(inner_last)
  );

  rosetta_loop_counter #(.W(CNT_W), .STEP(1)) u_outer (
    .clk(clk), .rst(rst), .load(load), .en(outer_en),
    .bound(outer_bound), .count(outer_idx), .last(outer_last)
  );

  rosetta_loop_counter #(.W(NOPS_W), .STEP(1)) u_nops (
    .clk(clk), .rst(rst), .load(load), .en(nops_step),
    .bound(nops_count - NOPS_W'(1)), .count(nops_idx_unused), .last(nops_last)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_mask_run[gi] = !inner_last || (LANE_W'(gi) <= tail_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= 1'b0;
      enof_reg    <= 1'b0;
      nops_go_reg <= 1'b0;
      tail_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        mode_reg    <= inst[INST_MODE];
        enof_reg    <= inst[INST_ENOF];
        nops_go_reg <= inst[INST_NOPS_EN] && (nops_count != '0);
        tail_reg    <= inner_bound[LANE_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ctrl       = '0;
    inst_done  = 1'b0;
    lane_mask  = '0;
    load       = 1'b0;
    inner_en   = 1'b0;
    outer_en   = 1'b0;
    nops_step  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (inst_valid) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        lane_mask = lane_mask_run;
        if (!stall) begin
          inner_en        = 1'b1;
          outer_en        = inner_last;
          ctrl.pam_x_ren  = 1'b1;
          ctrl.x_addr_wen = 1'b1;
          if (mode_reg) begin
            ctrl.pam_r_wen  = 1'b1;
            ctrl.r_addr_wen = 1'b1;
            ctrl.pam_y_ren  = !enof_reg;
            ctrl.pam_r_ren  = !enof_reg;
          end else begin
            ctrl.wm_ren = 1'b1;
            if (inner_last) begin
              ctrl.pam_r_wen  = 1'b1;
              ctrl.bm_ren     = 1'b1;
              ctrl.r_addr_wen = 1'b1;
              ctrl.x_addr_rst = 1'b1;
            end
          end
          if (inner_last && outer_last) begin
            inst_done  = 1'b1;
            state_next = nops_go_reg ? ST_NOPS : ST_FETCH;
          end
        end
      end
      ST_NOPS: begin
        if (!stall) begin
          ctrl.x_addr_rst = 1'b1;
          ctrl.r_addr_rst = 1'b1;
          nops_step       = 1'b1;
          if (nops_last) state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ctrl.im_ren     = 1'b1;
        ctrl.x_addr_rst = 1'b1;
        ctrl.r_addr_rst = 1'b1;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign inst_ready = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign beta_idx   = mode_reg ? '0 : inner_idx;
  assign p_idx      = mode_reg ? inner_idx : outer_idx;

  assign im_ren     = ctrl.im_ren;
  assign pam_x_ren  = ctrl.pam_x_ren;
  assign pam_y_ren  = ctrl.pam_y_ren;
  assign pam_r_ren  = ctrl.pam_r_ren;
  assign pam_r_wen  = ctrl.pam_r_wen;
  assign wm_ren     = ctrl.wm_ren;
  assign bm_ren     = ctrl.bm_ren;
  assign x_addr_wen = ctrl.x_addr_wen;
  assign r_addr_wen = ctrl.r_addr_wen;
  assign x_addr_rst = ctrl.x_addr_rst;
  assign r_addr_rst = ctrl.r_addr_rst;

endmodule
